// File: rtl/word_to_byte_tx.sv
// word_to_byte_tx
// Serializes one 8*NBYTES-bit word into a stream of bytes, LSB byte first.
// Only one word is held at a time. A new word is accepted only when the block
// is idle.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   clear       synchronous abort; the current word is discarded
//   word_in     word to transmit
//   word_valid  word_in is valid
//   word_ready  block can accept a word (high exactly in IDLE)
//   byte_out    current byte (registered)
//   byte_valid  byte_out is valid (registered)
//   byte_ready  downstream accepts byte_out
//   busy        a frame is in progress (registered)
//   frame_done  one-cycle pulse on re-entering IDLE after a completed frame
//
// Build option: define TX_CHECKSUM_EN to append one checksum byte to each
// frame. The checksum is the XOR of all data bytes in the frame.
//
// state | meaning
// IDLE  | waiting for a word; word_ready=1
// SEND  | presenting data byte[index]
// CHK   | presenting checksum byte (TX_CHECKSUM_EN only)
module word_to_byte_tx #(
    parameter int NBYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [8*NBYTES-1:0]   word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

`ifdef TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CHK = 2'd2} state_t;
    logic [7:0]           checksum;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

    state_t               state;
    logic [8*NBYTES-1:0]  shreg;   // bytes not yet loaded into byte_out
    logic [IDX_W-1:0]     index;

    assign word_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            index      <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef TX_CHECKSUM_EN
            checksum   <= 8'h00;
`endif
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                // Abort takes priority over any accept or byte transfer.
                state      <= IDLE;
                index      <= '0;
                byte_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (word_valid) begin
                            state      <= SEND;
                            byte_out   <= word_in[7:0];
                            shreg      <= word_in >> 8;
                            index      <= '0;
                            byte_valid <= 1'b1;
                            busy       <= 1'b1;
`ifdef TX_CHECKSUM_EN
                            checksum   <= 8'h00;
`endif
                        end
                    end
                    SEND: begin
                        // byte_valid is always high here, so byte_ready alone
                        // marks a transfer; when stalled, everything holds.
                        if (byte_ready) begin
                            index <= index + IDX_W'(1);
`ifdef TX_CHECKSUM_EN
                            checksum <= checksum ^ byte_out;
`endif
                            if (index == LAST_IDX) begin
`ifdef TX_CHECKSUM_EN
                                // The running checksum still lacks this last
                                // byte, so it is folded in here.
                                state    <= CHK;
                                byte_out <= checksum ^ byte_out;
`else
                                state      <= IDLE;
                                byte_valid <= 1'b0;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
`endif
                            end else begin
                                byte_out <= shreg[7:0];
                                shreg    <= shreg >> 8;
                            end
                        end
                    end
`ifdef TX_CHECKSUM_EN
                    CHK: begin
                        if (byte_ready) begin
                            state      <= IDLE;
                            byte_valid <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state      <= IDLE;
                        byte_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_word_to_byte_tx.sv
// Testbench for word_to_byte_tx (NBYTES=8). A queue model holds the bytes
// still owed for the current frame. Outputs are compared with this model on
// every falling edge. Hand-computed byte sequences pin the model.
module tb_word_to_byte_tx;

    localparam int NBYTES = 8;

    typedef logic [7:0] bq_t[$];

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic [8*NBYTES-1:0]  word_in;
    logic                 word_valid;
    logic                 word_ready;
    logic [7:0]           byte_out;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 busy;
    logic                 frame_done;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    bq_t q;        // model: bytes still to be transferred in this frame
    bit  exp_done; // model: frame_done expected this cycle
    bq_t logq;     // bytes actually seen transferring
    bq_t e;

    always #5 clk = ~clk;

    word_to_byte_tx #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: at each edge, apply the frame-level rules to the queue of owed bytes.
    initial begin
        exp_done = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            exp_done = 1'b0;
            if (rst) begin
                q.delete();
            end else if (clear) begin
                q.delete();
            end else if (q.size() == 0) begin
                if (word_valid) begin
                    logic [7:0] x;
                    x = 8'h00;
                    for (int i = 0; i < NBYTES; i++) begin
                        q.push_back(word_in[8*i +: 8]);
                        x = x ^ word_in[8*i +: 8];
                    end
`ifdef TX_CHECKSUM_EN
                    q.push_back(x);
`endif
                end
            end else if (byte_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_done = 1'b1;
            end
        end
    end

    // Compare process.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_done) done_cnt++;
                chk("word_ready", 64'(word_ready), 64'(q.size() == 0));
                chk("busy",       64'(busy),       64'(q.size() != 0));
                chk("byte_valid", 64'(byte_valid), 64'(q.size() != 0));
                if (q.size() != 0) chk("byte_out", 64'(byte_out), 64'(q[0]));
                chk("frame_done", 64'(frame_done), 64'(exp_done));
                if (byte_valid && byte_ready && !clear) logq.push_back(byte_out);
            end
        end
    end

    task automatic send_word(input logic [63:0] w);
        @(posedge clk); #1;
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic cmp_log(input string name, input bq_t exp);
        chk({name, "_len"}, 64'(logq.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < logq.size()) chk({name, "_byte"}, 64'(logq[i]), 64'(exp[i]));
        logq.delete();
    endtask

    initial begin
        int d0;
        rst        = 1'b1;
        clear      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        byte_ready = 1'b1;
        #12;
        chk("rst_byte_out",   64'(byte_out),   64'(8'h00));
        chk("rst_byte_valid", 64'(byte_valid), 64'(0));
        chk("rst_busy",       64'(busy),       64'(0));
        chk("rst_word_ready", 64'(word_ready), 64'(1));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        logq.delete();

        // Basic frame.
        d0 = done_cnt;
        send_word(64'h0807060504030201);
        wait_done("basic");
        chk("basic_word_ready", 64'(word_ready), 64'(1));
        @(negedge clk);
        chk("basic_done_count", 64'(done_cnt - d0), 64'(1));
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef TX_CHECKSUM_EN
        e.push_back(8'h08);
`endif
        cmp_log("basic", e);

        // Backpressure: stall three cycles on byte 03.
        send_word(64'h0807060504030201);
        @(posedge clk); #1;
        @(posedge clk); #1;
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_byte_out",   64'(byte_out),   64'(8'h03));
            chk("stall_byte_valid", 64'(byte_valid), 64'(1));
            @(posedge clk); #1;
        end
        byte_ready = 1'b1;
        wait_done("stall");
        @(negedge clk);
        cmp_log("stall", e);

        // All-ones word: checksum byte is 00.
        send_word(64'hFFFFFFFFFFFFFFFF);
        wait_done("ones");
        @(negedge clk);
        e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef TX_CHECKSUM_EN
        e.push_back(8'h00);
`endif
        cmp_log("ones", e);

        // Clear after byte 02 transfers.
        d0 = done_cnt;
        send_word(64'h0807060504030201);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_byte_valid", 64'(byte_valid), 64'(0));
        chk("clear_frame_done", 64'(frame_done), 64'(0));
        repeat (3) @(negedge clk);
        chk("clear_no_done", 64'(done_cnt - d0), 64'(0));
        send_word(64'hAABBCCDDEEFF0011);
        wait_done("after_clear");
        @(negedge clk);
        e = '{8'h01, 8'h02, 8'h11, 8'h00, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef TX_CHECKSUM_EN
        e.push_back(8'h00);
`endif
        cmp_log("after_clear", e);

        // Back-to-back: word_valid held high across two frames.
        @(posedge clk); #1;
        word_in    = 64'h1122334455667788;
        word_valid = 1'b1;
        @(posedge clk); #1;
        word_in    = 64'h0F0E0D0C0B0A0908;
        wait_done("b2b_first");
        chk("b2b_gap_valid", 64'(byte_valid), 64'(0));
        chk("b2b_gap_ready", 64'(word_ready), 64'(1));
        @(posedge clk); #1;
        word_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_first", 64'(byte_out), 64'(8'h08));
        wait_done("b2b_second");
        @(negedge clk);
        e = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef TX_CHECKSUM_EN
        e.push_back(8'h88);
`endif
        e.push_back(8'h08); e.push_back(8'h09); e.push_back(8'h0A); e.push_back(8'h0B);
        e.push_back(8'h0C); e.push_back(8'h0D); e.push_back(8'h0E); e.push_back(8'h0F);
`ifdef TX_CHECKSUM_EN
        e.push_back(8'h00);
`endif
        cmp_log("b2b", e);

        // Asynchronous reset mid-frame.
        d0 = done_cnt;
        send_word(64'h0807060504030201);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_byte_valid", 64'(byte_valid), 64'(0));
        chk("arst_busy",       64'(busy),       64'(0));
        chk("arst_word_ready", 64'(word_ready), 64'(1));
        chk("arst_byte_out",   64'(byte_out),   64'(8'h00));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_done", 64'(done_cnt - d0), 64'(0));
        logq.delete();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
